// File: rtl/ffo_scan_if.sv
// Handshake bundle between an ffo_scan engine and its controller/consumer.
// The master drives start/mode/b/pready; the scanner returns positions and status.
interface ffo_scan_if #(
    parameter int N = 32
);
    localparam int PW = $clog2(N);
    localparam int CW = $clog2(N + 1);

    logic          start;
    logic          mode;
    logic [0:N-1]  b;
    logic          busy;
    logic          pv;
    logic [PW-1:0] p;
    logic          last;
    logic          pready;
    logic          ready;
    logic          v;
    logic [CW-1:0] count;

    modport master (
        output start, mode, b, pready,
        input  busy, pv, p, last, ready, v, count
    );

    modport slave (
        input  start, mode, b, pready,
        output busy, pv, p, last, ready, v, count
    );
endinterface

// File: rtl/ffo_scan.sv
// Multi-cycle find-first-one / one-enumerator: scans W bits per clock of an
// N-bit vector (bit 0 highest priority) and streams set-bit positions out.
//
// state | meaning
// IDLE  | waiting for start; results of the previous scan held
// SCAN  | examining chunk k of the working copy
// EMIT  | presenting position p until the consumer accepts it
// DONE  | one-cycle completion pulse
module ffo_scan #(
    parameter int N = 32,
    parameter int W = 8
) (
    input logic      clock,
    input logic      reset,
    ffo_scan_if.slave bus
);
    localparam int NC = N / W;
    localparam int PW = $clog2(N);
    localparam int KW = (NC > 1) ? $clog2(NC) : 1;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

    state_t        state, state_nx;
    logic [0:N-1]  work;
    logic [0:N-1]  work_clr;
    logic [KW-1:0] k;
    logic          mode_q;
    logic          v_q;
    logic [PW-1:0] p_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] base;
    logic [PW-1:0] off;
    logic          hit;
    logic          k_last;
    logic          rest_zero;

    assign base   = PW'(int'(k) * W);
    assign k_last = (int'(k) == NC - 1);

    // Descending loop so the lowest (highest-priority) set bit wins.
    always_comb begin
        hit = 1'b0;
        off = '0;
        for (int j = W - 1; j >= 0; j--) begin
            if (work[base + PW'(j)]) begin
                hit = 1'b1;
                off = PW'(j);
            end
        end
    end

    always_comb begin
        work_clr       = work;
        work_clr[p_q]  = 1'b0;
    end

    assign rest_zero = (work_clr == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.start) state_nx = SCAN;
            SCAN: begin
                if (hit)         state_nx = EMIT;
                else if (k_last) state_nx = DONE;
            end
            EMIT: if (bus.pready) state_nx = mode_q ? SCAN : DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            work    <= '0;
            k       <= '0;
            mode_q  <= 1'b0;
            v_q     <= 1'b0;
            p_q     <= '0;
            count_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        work    <= bus.b;
                        k       <= '0;
                        mode_q  <= bus.mode;
                        v_q     <= 1'b0;
                        p_q     <= '0;
                        count_q <= '0;
                    end
                end
                SCAN: begin
                    if (hit)          p_q <= base + off;
                    else if (!k_last) k   <= k + KW'(1);
                end
                // k is left alone so the same chunk is rescanned after each emit.
                EMIT: begin
                    if (bus.pready) begin
                        work[p_q] <= 1'b0;
                        count_q   <= count_q + CW'(1);
                        v_q       <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.pv    = (state == EMIT);
    assign bus.p     = p_q;
    assign bus.last  = (state == EMIT) && (!mode_q || rest_zero);
    assign bus.ready = (state == DONE);
    assign bus.v     = v_q;
    assign bus.count = count_q;
endmodule

// File: tb/tb_ffo_scan.sv
// Directed bench for ffo_scan: one W=8 instance for timing/handshake cases
// and one W=1 instance for full bit-by-bit enumeration.
module tb_ffo_scan;
    logic clock = 1'b0;
    logic reset;
    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   exp_q[$];

    ffo_scan_if #(.N(32)) if8();
    ffo_scan_if #(.N(32)) if1();

    ffo_scan #(.N(32), .W(8)) u8 (.clock(clock), .reset(reset), .bus(if8.slave));
    ffo_scan #(.N(32), .W(1)) u1 (.clock(clock), .reset(reset), .bus(if1.slave));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int ffo32(input logic [0:31] x);
        for (int i = 0; i < 32; i++) begin
            if (x[i]) return i;
        end
        return -1;
    endfunction

    // Mode 0, pready high: single position, then ready one cycle later.
    task automatic run_first(input logic [0:31] vec, input string tag);
        int e;
        int cyc;
        e = ffo32(vec);
        if8.b      = vec;
        if8.mode   = 1'b0;
        if8.pready = 1'b1;
        if8.start  = 1'b1;
        step();
        if8.start = 1'b0;
        if8.b     = ~vec;
        cyc = 0;
        while (!if8.pv && cyc < 40) begin
            step();
            cyc++;
        end
        chk({tag, "_pv_cycle"}, cyc, e / 8 + 1);
        chk({tag, "_p"}, if8.p, e);
        chk({tag, "_last"}, if8.last, 1);
        step();
        chk({tag, "_ready"}, if8.ready, 1);
        chk({tag, "_v"}, if8.v, 1);
        chk({tag, "_count"}, if8.count, 1);
        chk({tag, "_pv_drop"}, if8.pv, 0);
        step();
        chk({tag, "_idle"}, if8.busy, 0);
    endtask

    // Mode 1 on the W=8 instance; expected positions come from exp_q.
    task automatic run_enum(input logic [0:31] vec, input int stall, input int ready_cyc, input string tag);
        int cyc;
        int n;
        int e;
        bit stalled;
        if8.b      = vec;
        if8.mode   = 1'b1;
        if8.pready = (stall == 0);
        if8.start  = 1'b1;
        step();
        if8.start = 1'b0;
        cyc = 0;
        n = 0;
        stalled = 1'b0;
        while (!if8.ready && cyc < 200) begin
            if (if8.pv) begin
                e = (n < exp_q.size()) ? exp_q[n] : -1;
                chk({tag, "_p"}, if8.p, e);
                chk({tag, "_last"}, if8.last, (n == exp_q.size() - 1));
                if (stall > 0 && !stalled) begin
                    for (int s = 0; s < stall; s++) begin
                        step();
                        cyc++;
                        chk({tag, "_stall_pv"}, if8.pv, 1);
                        chk({tag, "_stall_p"}, if8.p, e);
                        chk({tag, "_stall_last"}, if8.last, 0);
                    end
                    if8.pready = 1'b1;
                    stalled = 1'b1;
                end
                n++;
            end
            step();
            cyc++;
        end
        chk({tag, "_ready_cycle"}, cyc, ready_cyc);
        chk({tag, "_n"}, n, exp_q.size());
        chk({tag, "_count"}, if8.count, exp_q.size());
        chk({tag, "_v"}, if8.v, 1);
        repeat (3) step();
        chk({tag, "_hold_count"}, if8.count, exp_q.size());
        chk({tag, "_hold_v"}, if8.v, 1);
        chk({tag, "_hold_busy"}, if8.busy, 0);
    endtask

    initial begin
        logic [0:31] vec;
        int cyc;
        int n;

        if8.start = 1'b0; if8.mode = 1'b0; if8.b = '0; if8.pready = 1'b0;
        if1.start = 1'b0; if1.mode = 1'b0; if1.b = '0; if1.pready = 1'b0;
        reset = 1'b0;
        #2 reset = 1'b1;
        #2;
        chk("rst_busy", if8.busy, 0);
        chk("rst_pv", if8.pv, 0);
        chk("rst_p", if8.p, 0);
        chk("rst_last", if8.last, 0);
        chk("rst_ready", if8.ready, 0);
        chk("rst_v", if8.v, 0);
        chk("rst_count", if8.count, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Empty vector: ready after edge 4, busy gone after edge 5.
        if8.b = '0; if8.mode = 1'b0; if8.pready = 1'b1; if8.start = 1'b1;
        step();
        if8.start = 1'b0;
        chk("empty_busy0", if8.busy, 1);
        for (int c = 1; c <= 5; c++) begin
            step();
            chk($sformatf("empty_pv_c%0d", c), if8.pv, 0);
            chk($sformatf("empty_ready_c%0d", c), if8.ready, (c == 4));
            chk($sformatf("empty_busy_c%0d", c), if8.busy, (c < 5));
        end
        chk("empty_v", if8.v, 0);
        chk("empty_count", if8.count, 0);

        for (int i = 0; i < 32; i++) begin
            vec = '0;
            vec[i] = 1'b1;
            run_first(vec, $sformatf("walk%0d", i));
        end

        vec = '0;
        vec[3] = 1'b1; vec[4] = 1'b1; vec[17] = 1'b1; vec[31] = 1'b1;
        exp_q = '{3, 4, 17, 31};
        run_enum(vec, 0, 12, "enum");
        run_enum(vec, 5, 17, "stall");

        // start re-pulsed in SCAN and EMIT, then reset while stalled in EMIT.
        if8.b = vec; if8.mode = 1'b1; if8.pready = 1'b0; if8.start = 1'b1;
        step();
        chk("restart_scan_busy", if8.busy, 1);
        step();
        chk("restart_emit_pv", if8.pv, 1);
        chk("restart_emit_p", if8.p, 3);
        step();
        chk("restart_hold_pv", if8.pv, 1);
        chk("restart_hold_p", if8.p, 3);
        chk("restart_hold_count", if8.count, 0);
        if8.start = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", if8.busy, 0);
        chk("midrst_pv", if8.pv, 0);
        chk("midrst_p", if8.p, 0);
        chk("midrst_last", if8.last, 0);
        chk("midrst_ready", if8.ready, 0);
        chk("midrst_v", if8.v, 0);
        chk("midrst_count", if8.count, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        vec = '0;
        vec[5] = 1'b1;
        if8.b = vec; if8.mode = 1'b0; if8.pready = 1'b1; if8.start = 1'b1;
        step();
        if8.start = 1'b0;
        step();
        chk("post_rst_pv", if8.pv, 1);
        chk("post_rst_p", if8.p, 5);
        chk("post_rst_last", if8.last, 1);
        step();
        chk("post_rst_ready", if8.ready, 1);
        chk("post_rst_count", if8.count, 1);
        chk("post_rst_v", if8.v, 1);

        // W=1, all ones, enumerate: 3 cycles per bit, ready after edge 96.
        if1.b = '1; if1.mode = 1'b1; if1.pready = 1'b1; if1.start = 1'b1;
        step();
        if1.start = 1'b0;
        cyc = 0;
        n = 0;
        while (!if1.ready && cyc < 300) begin
            if (if1.pv) begin
                chk($sformatf("w1_p%0d", n), if1.p, n);
                chk($sformatf("w1_last%0d", n), if1.last, (n == 31));
                n++;
            end
            step();
            cyc++;
        end
        chk("w1_ready_cycle", cyc, 96);
        chk("w1_n", n, 32);
        chk("w1_count", if1.count, 32);
        chk("w1_v", if1.v, 1);
        step();
        chk("w1_idle", if1.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
